// File: rtl/data_memory_responder.sv
// Data-memory responder: word-organised RAM plus MMIO (64-bit cycle counter, debug byte FIFO).
// Loads are combinational from pre-edge state; stores and MMIO side effects commit at the rising edge.
module data_memory_responder #(
  parameter int unsigned WORD_COUNT = 1024,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] memory_address,
  input  logic [2:0]  memory_write_sections,
  input  logic [31:0] memory_write_value,
  output logic [31:0] memory_read_value,
  output logic        debug_valid,
  output logic [7:0]  debug_data,
  input  logic        debug_ready
);

  localparam int unsigned IDX_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [31:0] ADDR_COUNTER_LO = 32'h8000_0000;
  localparam logic [31:0] ADDR_COUNTER_HI = 32'h8000_0004;
  localparam logic [31:0] ADDR_DEBUG_TX   = 32'h8000_0008;
  localparam logic [31:0] ADDR_STATUS     = 32'h8000_000C;

  logic [31:0]      ram [WORD_COUNT];
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [63:0]      counter;
  logic [31:0]      counter_shadow;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;

  logic             is_write;
  logic             ram_hit;
  logic [IDX_W-1:0] word_idx;
  logic [1:0]       offset;
  logic [3:0]       lane_mask;
  logic [31:0]      lane_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic             enq_req;
  logic             enq;
  logic             deq;
  logic             drop;
  logic             status_clear;
  logic             lo_read;
  logic [31:0]      status_word;

  assign is_write  = (memory_write_sections != 3'b000);
  assign ram_hit   = ~memory_address[31] && ({3'b000, memory_address[30:2]} < WORD_COUNT);
  assign word_idx  = memory_address[IDX_W+1:2];
  assign offset    = memory_address[1:0];
  // Lanes shifted past byte 3 fall off the top: no spill into the next word.
  assign lane_mask = 4'({memory_write_sections[2], memory_write_sections[2],
                         memory_write_sections[1], memory_write_sections[0]} << offset);
  assign lane_data = memory_write_value << {offset, 3'b000};

  assign fifo_full    = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty   = (count == '0);
  assign debug_valid  = ~fifo_empty;
  assign debug_data   = fifo_mem[rd_ptr];
  assign deq          = debug_valid && debug_ready;
  assign enq_req      = (memory_address == ADDR_DEBUG_TX) && is_write;
  assign enq          = enq_req && (~fifo_full || deq);
  assign drop         = enq_req && fifo_full && ~deq;
  assign status_clear = (memory_address == ADDR_STATUS) && is_write && memory_write_value[2];
  assign lo_read      = (memory_address == ADDR_COUNTER_LO) && ~is_write;

  always_ff @(posedge clk) begin
    if (reset_n && ram_hit && is_write) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lane_mask[i]) ram[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && enq) fifo_mem[wr_ptr] <= memory_write_value[7:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      counter        <= '0;
      counter_shadow <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      overflow       <= 1'b0;
    end else begin
      counter <= counter + 64'd1;
      if (lo_read) counter_shadow <= counter[63:32];
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop)              overflow <= 1'b1;
      else if (status_clear) overflow <= 1'b0;
    end
  end

  always_comb begin
    status_word      = '0;
    status_word[0]   = fifo_full;
    status_word[1]   = fifo_empty;
    status_word[2]   = overflow;
    status_word[7:4] = 4'(count);
  end

  always_comb begin
    memory_read_value = '0;
    if (ram_hit) begin
      memory_read_value = ram[word_idx] >> {offset, 3'b000};
    end else begin
      case (memory_address)
        ADDR_COUNTER_LO: memory_read_value = counter[31:0];
        ADDR_COUNTER_HI: memory_read_value = counter_shadow;
        ADDR_STATUS:     memory_read_value = status_word;
        default:         memory_read_value = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: directed scenarios plus randomized traffic against a
// byte-addressed memory / queue based reference model.
module tb_data_memory_responder;

  localparam int unsigned WC = 1024;
  localparam logic [31:0] A_LO   = 32'h8000_0000;
  localparam logic [31:0] A_HI   = 32'h8000_0004;
  localparam logic [31:0] A_TX   = 32'h8000_0008;
  localparam logic [31:0] A_ST   = 32'h8000_000C;
  localparam logic [31:0] A_IDLE = 32'h8000_0010;

  logic        clk;
  logic        reset_n;
  logic [31:0] memory_address;
  logic [2:0]  memory_write_sections;
  logic [31:0] memory_write_value;
  logic [31:0] memory_read_value;
  logic        debug_valid;
  logic [7:0]  debug_data;
  logic        debug_ready;

  data_memory_responder #(.WORD_COUNT(WC), .FIFO_DEPTH(8)) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .memory_address        (memory_address),
    .memory_write_sections (memory_write_sections),
    .memory_write_value    (memory_write_value),
    .memory_read_value     (memory_read_value),
    .debug_valid           (debug_valid),
    .debug_data            (debug_data),
    .debug_ready           (debug_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd_val;
  logic        dv_val;
  logic [7:0]  dd_val;

  logic [63:0] m_cnt;
  logic [31:0] m_shadow;
  logic        m_ovf;
  logic [7:0]  m_q[$];
  logic [7:0]  mb[256];
  bit          kn[256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit lane_on(input logic [2:0] s, input int k);
    return (k == 0) ? s[0] : (k == 1) ? s[1] : s[2];
  endfunction

  function automatic void model_read(input logic [31:0] a, output logic [31:0] e, output bit ok);
    int unsigned base;
    ok = 1;
    e  = '0;
    if (!a[31]) begin
      if (a < 4 * WC) begin
        for (int k = 0; k < 4; k++) begin
          if (int'(a[1:0]) + k < 4) begin
            base = a + k;
            if (base >= 256 || !kn[base]) ok = 0;
            else e[8*k +: 8] = mb[base];
          end
        end
      end
    end else begin
      case (a)
        A_LO:    e = m_cnt[31:0];
        A_HI:    e = m_shadow;
        A_ST:    e = {24'b0, 4'(m_q.size()), 1'b0, m_ovf,
                      (m_q.size() == 0), (m_q.size() == 8)};
        default: e = '0;
      endcase
    end
  endfunction

  task automatic model_reset();
    m_cnt = '0;
    m_shadow = '0;
    m_ovf = 1'b0;
    m_q.delete();
  endtask

  task automatic step(input logic [31:0] a, input logic [2:0] s, input logic [31:0] w,
                      input logic rdy, input logic rn);
    logic [31:0] e;
    bit ok;
    bit deq;
    bit was_full;
    memory_address = a;
    memory_write_sections = s;
    memory_write_value = w;
    debug_ready = rdy;
    reset_n = rn;
    #4;
    rd_val = memory_read_value;
    dv_val = debug_valid;
    dd_val = debug_data;
    model_read(a, e, ok);
    if (ok) check("rdata", rd_val, e);
    check("dvalid", {31'b0, dv_val}, {31'b0, (m_q.size() != 0)});
    if (m_q.size() != 0) check("ddata", {24'b0, dd_val}, {24'b0, m_q[0]});
    @(posedge clk);
    if (!rn) begin
      model_reset();
    end else begin
      if (a < 256 && s != 3'b000) begin
        for (int k = 0; k < 4; k++) begin
          if (lane_on(s, k) && int'(a[1:0]) + k < 4) begin
            mb[a + k] = w[8*k +: 8];
            kn[a + k] = 1;
          end
        end
      end
      if (a == A_LO && s == 3'b000) m_shadow = m_cnt[63:32];
      m_cnt = m_cnt + 64'd1;
      was_full = (m_q.size() == 8);
      deq = (m_q.size() != 0) && rdy;
      if (deq) void'(m_q.pop_front());
      if (a == A_TX && s != 3'b000) begin
        if (was_full && !deq) m_ovf = 1'b1;
        else m_q.push_back(w[7:0]);
      end
      if (a == A_ST && s != 3'b000 && w[2]) m_ovf = 1'b0;
    end
    @(negedge clk);
  endtask

  logic [2:0]  secs[4] = '{3'b000, 3'b001, 3'b011, 3'b111};
  logic [31:0] ra;
  logic [2:0]  rs;
  logic [31:0] rw;

  initial begin
    for (int i = 0; i < 256; i++) kn[i] = 0;
    memory_address = A_IDLE;
    memory_write_sections = 3'b000;
    memory_write_value = '0;
    debug_ready = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();

    // reset state and counter start value
    step(A_ST, 3'b000, 0, 0, 1);
    check("rst_status", rd_val, 32'h2);
    check("rst_valid", {31'b0, dv_val}, 32'h0);
    repeat (4) step(A_IDLE, 3'b000, 0, 0, 1);
    step(A_LO, 3'b000, 0, 0, 1);
    check("cnt5", rd_val, 32'd5);

    // byte/half lanes
    step(32'h10, 3'b111, 32'h1122_3344, 0, 1);
    step(32'h11, 3'b001, 32'h0000_00AA, 0, 1);
    step(32'h12, 3'b011, 32'h0000_BEEF, 0, 1);
    step(32'h10, 3'b000, 0, 0, 1);
    check("lanes_10", rd_val, 32'hBEEF_AA44);
    step(32'h11, 3'b000, 0, 0, 1);
    check("lanes_11", rd_val, 32'h00BE_EFAA);

    // boundary truncation
    step(32'h20, 3'b111, 0, 0, 1);
    step(32'h24, 3'b111, 0, 0, 1);
    step(32'h23, 3'b111, 32'hFFFF_FFFF, 0, 1);
    step(32'h20, 3'b000, 0, 0, 1);
    check("trunc_20", rd_val, 32'hFF00_0000);
    step(32'h24, 3'b000, 0, 0, 1);
    check("trunc_24", rd_val, 32'h0);
    step(4 * WC, 3'b000, 0, 0, 1);
    check("unmapped_ram", rd_val, 32'h0);

    // counter coherence across a low-word wrap
    force dut.counter = 64'h0000_0000_FFFF_FFFF;
    release dut.counter;
    m_cnt = 64'h0000_0000_FFFF_FFFF;
    step(A_LO, 3'b000, 0, 0, 1);
    check("wrap_lo", rd_val, 32'hFFFF_FFFF);
    step(A_HI, 3'b000, 0, 0, 1);
    check("wrap_hi", rd_val, 32'h0);

    // FIFO full / overflow
    for (int i = 0; i < 9; i++) step(A_TX, 3'b111, 32'h41 + i, 0, 1);
    step(A_ST, 3'b000, 0, 0, 1);
    check("ovf_status", rd_val, 32'h85);
    for (int i = 0; i < 8; i++) begin
      step(A_IDLE, 3'b000, 0, 1, 1);
      check("drain_ovf", {24'b0, dd_val}, 32'h41 + i);
    end
    step(A_ST, 3'b111, 32'h4, 0, 1);
    step(A_ST, 3'b000, 0, 0, 1);
    check("ovf_clear", rd_val, 32'h2);

    // simultaneous enqueue and dequeue while full
    for (int i = 0; i < 8; i++) step(A_TX, 3'b001, 32'h51 + i, 0, 1);
    step(A_TX, 3'b001, 32'h5A, 1, 1);
    check("sim_head", {24'b0, dd_val}, 32'h51);
    step(A_ST, 3'b000, 0, 0, 1);
    check("sim_status", rd_val, 32'h81);
    for (int i = 0; i < 8; i++) begin
      step(A_IDLE, 3'b000, 0, 1, 1);
      check("drain_sim", {24'b0, dd_val}, (i < 7) ? 32'h52 + i : 32'h5A);
    end

    // reset in the middle of activity
    for (int i = 0; i < 3; i++) step(A_TX, 3'b111, 32'h61 + i, 0, 1);
    step(A_TX, 3'b111, 32'h77, 0, 0);
    step(A_LO, 3'b000, 0, 0, 1);
    check("mrst_cnt", rd_val, 32'h0);
    check("mrst_valid", {31'b0, dv_val}, 32'h0);
    step(A_ST, 3'b000, 0, 0, 1);
    check("mrst_status", rd_val, 32'h2);
    step(32'h10, 3'b000, 0, 0, 1);
    check("mrst_ram", rd_val, 32'hBEEF_AA44);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      rs = secs[$urandom_range(0, 3)];
      rw = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: ra = $urandom_range(0, 255);
        4:          begin ra = A_TX; rs = secs[$urandom_range(1, 3)]; end
        5:          ra = A_ST;
        6:          begin ra = A_LO; rs = 3'b000; end
        7:          begin ra = A_HI; rs = 3'b000; end
        8:          ra = ($urandom_range(0, 1) != 0) ? 32'h0000_1000 + $urandom_range(0, 4095)
                                                     : 32'hC000_0000 + $urandom_range(0, 255);
        default:    ra = A_TX;
      endcase
      step(ra, rs, rw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 49) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
